// File: rtl/reset_sequencer_pkg.sv
// Shared types for the boot reset sequencer: FSM state encoding and stage index.
package gm64_reset_pkg;

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    WAIT_ACK = 3'd1,
    GAP      = 3'd2,
    READY    = 3'd3,
    ERROR    = 3'd4
  } rst_seq_state_t;

  typedef logic [2:0] stage_idx_t;

  localparam int unsigned MAX_STAGES = 7;

endpackage

// File: rtl/reset_sequencer_btn_debounce.sv
// Front-panel button conditioning: 2-FF synchroniser followed by a stable-low counter.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic pressed
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_r;
  logic          sync2_r;
  logic [CW-1:0] cnt_r;
  logic          pressed_r;

  // Synchronise the raw button and count consecutive low samples; counter saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      cnt_r     <= '0;
      pressed_r <= 1'b0;
    end else begin
      sync1_r <= btn_n;
      sync2_r <= sync1_r;
      if (sync2_r) begin
        cnt_r     <= '0;
        pressed_r <= 1'b0;
      end else begin
        // The sample that brings the run to DEBOUNCE_CYCLES asserts pressed.
        pressed_r <= (cnt_r >= CW'(DEBOUNCE_CYCLES - 1));
        if (cnt_r != CW'(DEBOUNCE_CYCLES)) begin
          cnt_r <= cnt_r + CW'(1);
        end else begin
          cnt_r <= cnt_r;
        end
      end
    end
  end

  assign pressed = pressed_r;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release with per-stage init acknowledge and debounced restart button.
// Optional stage-ack watchdog enabled by defining RESET_SEQ_TIMEOUT_EN.
module reset_sequencer
  import gm64_reset_pkg::*;
#(
  parameter int unsigned NUM_STAGES      = 3,
  parameter int unsigned HOLD_CYCLES     = 1000,
  parameter int unsigned GAP_CYCLES      = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned TIMEOUT_CYCLES  = 500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_n,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic [2:0]            cur_stage,
  output logic                  sys_ready,
  output logic                  timeout_err
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned AW = MAX_STAGES + 1;

  rst_seq_state_t        state_r;
  logic [HW-1:0]         hold_cnt_r;
  logic [GW-1:0]         gap_cnt_r;
  logic [NUM_STAGES-1:0] rel_r;
  stage_idx_t            cur_r;
  logic                  ready_r;
  logic                  pressed_s;
  logic [AW-1:0]         ack_ext_s;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .reset  (reset),
    .btn_n  (btn_n),
    .pressed(pressed_s)
  );

  // Widen the ack vector so a full 3-bit stage index can select from it.
  assign ack_ext_s = AW'(stage_ack);

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_r;
  logic          err_r;
`endif

  // Sequencer FSM with its counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset || pressed_s) begin
      state_r    <= HOLD;
      hold_cnt_r <= '0;
      gap_cnt_r  <= '0;
      rel_r      <= '0;
      cur_r      <= 3'd0;
      ready_r    <= 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
      to_cnt_r   <= '0;
      err_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        HOLD: begin
          if (hold_cnt_r == HW'(HOLD_CYCLES - 1)) begin
            rel_r   <= NUM_STAGES'(1);
            state_r <= WAIT_ACK;
`ifdef RESET_SEQ_TIMEOUT_EN
            to_cnt_r <= '0;
`endif
          end else begin
            hold_cnt_r <= hold_cnt_r + HW'(1);
          end
        end
        WAIT_ACK: begin
          // Ack wins over a coincident timeout terminal count.
          if (ack_ext_s[cur_r]) begin
            if (cur_r == stage_idx_t'(NUM_STAGES - 1)) begin
              state_r <= READY;
              ready_r <= 1'b1;
              cur_r   <= stage_idx_t'(NUM_STAGES);
            end else begin
              state_r   <= GAP;
              gap_cnt_r <= '0;
            end
          end
`ifdef RESET_SEQ_TIMEOUT_EN
          else if (to_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
            state_r <= ERROR;
            rel_r   <= '0;
            err_r   <= 1'b1;
          end else begin
            to_cnt_r <= to_cnt_r + TW'(1);
          end
`else
          else begin
            state_r <= WAIT_ACK;
          end
`endif
        end
        GAP: begin
          if (gap_cnt_r == GW'(GAP_CYCLES - 1)) begin
            rel_r   <= (rel_r << 1) | NUM_STAGES'(1);
            cur_r   <= cur_r + 3'd1;
            state_r <= WAIT_ACK;
`ifdef RESET_SEQ_TIMEOUT_EN
            to_cnt_r <= '0;
`endif
          end else begin
            gap_cnt_r <= gap_cnt_r + GW'(1);
          end
        end
        READY: state_r <= READY;
        ERROR: state_r <= ERROR;
        default: begin
          state_r    <= HOLD;
          hold_cnt_r <= '0;
          rel_r      <= '0;
          cur_r      <= 3'd0;
          ready_r    <= 1'b0;
        end
      endcase
    end
  end

  assign stage_rst_n = rel_r;
  assign cur_stage   = cur_r;
  assign sys_ready   = ready_r;
`ifdef RESET_SEQ_TIMEOUT_EN
  assign timeout_err = err_r;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
